// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A, B and sel bytes from a ready/valid stream,
// presents them to an external combinational/pipelined ALU, waits ALU_LAT
// cycles and captures the ALU result into a one-deep output register.
module alu_op_sequencer #(
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic signed [7:0] A,
   output logic signed [7:0] B,
   output logic [2:0]        sel,
   input  logic signed [7:0] C,
   input  logic              Z,
   output logic signed [7:0] m_data,
   output logic              m_zero,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy
);

   typedef enum logic [1:0] {
      GET_A   = 2'd0,
      GET_B   = 2'd1,
      GET_SEL = 2'd2,
      WAIT    = 2'd3
   } state_t;

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

   state_t             state_q, state_d;
   logic signed [7:0]  a_q, a_d;
   logic signed [7:0]  b_q, b_d;
   logic [2:0]         sel_q, sel_d;
   logic [2:0]         cnt_q, cnt_d;
   logic signed [7:0]  m_data_q, m_data_d;
   logic               m_zero_q, m_zero_d;
   logic               m_valid_q, m_valid_d;

   logic               accept;
   logic               xfer;
   logic               capture;

   // State register; reset drops any partial triplet and any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= GET_A;
         a_q       <= '0;
         b_q       <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         m_data_q  <= '0;
         m_zero_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         m_data_q  <= m_data_d;
         m_zero_q  <= m_zero_d;
         m_valid_q <= m_valid_d;
      end
   end

   // Next-state logic: byte collection, latency countdown and result capture.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      m_data_d  = m_data_q;
      m_zero_d  = m_zero_q;
      m_valid_d = m_valid_q;

      accept  = (state_q != WAIT);
      xfer    = accept && s_valid;
      // A finished result may only be captured if the output slot is free or
      // is being emptied on this same edge; otherwise the FSM stalls in WAIT.
      capture = (state_q == WAIT) && (cnt_q == 3'd0) && (!m_valid_q || m_ready);

      // Delivery empties the slot unless a new result replaces it.
      if (m_ready) begin
         m_valid_d = 1'b0;
      end

      unique case (state_q)
         GET_A: begin
            if (xfer) begin
               a_d     = s_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (xfer) begin
               b_d     = s_data;
               state_d = GET_SEL;
            end
         end
         GET_SEL: begin
            if (xfer) begin
               sel_d   = s_data[2:0];
               cnt_d   = LAT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else if (capture) begin
               m_data_d  = C;
               m_zero_d  = Z;
               m_valid_d = 1'b1;
               state_d   = GET_A;
            end
         end
         default: begin
            state_d = GET_A;
         end
      endcase
   end

   // Output drive; s_ready is forced low combinationally while reset is held.
   always_comb begin
      s_ready = accept && !rst;
      busy    = (state_q != GET_A);
      A       = a_q;
      B       = b_q;
      sel     = sel_q;
      m_data  = m_data_q;
      m_zero  = m_zero_q;
      m_valid = m_valid_q;
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one ALU_LAT=1 instance for the
// functional scenarios plus ALU_LAT=0 and ALU_LAT=4 instances for latency.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main instance (ALU_LAT = 1)
   logic [7:0]        s_data;
   logic              s_valid, s_ready;
   logic signed [7:0] A, B, C, m_data;
   logic [2:0]        sel;
   logic              Z, m_zero, m_valid, m_ready, busy;

   // Latency instances share stimulus
   logic [7:0]        l_s_data;
   logic              l_s_valid;
   logic signed [7:0] l_C;
   logic              l_Z, l_m_ready;
   logic              s_ready0, m_zero0, m_valid0, busy0;
   logic signed [7:0] a0, b0, m_data0;
   logic [2:0]        sel0;
   logic              s_ready4, m_zero4, m_valid4, busy4;
   logic signed [7:0] a4, b4, m_data4;
   logic [2:0]        sel4;

   int total = 0;
   int bad   = 0;

   alu_op_sequencer #(.ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .A(A), .B(B), .sel(sel), .C(C), .Z(Z), .m_data(m_data), .m_zero(m_zero),
      .m_valid(m_valid), .m_ready(m_ready), .busy(busy));

   alu_op_sequencer #(.ALU_LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .s_data(l_s_data), .s_valid(l_s_valid), .s_ready(s_ready0),
      .A(a0), .B(b0), .sel(sel0), .C(l_C), .Z(l_Z), .m_data(m_data0), .m_zero(m_zero0),
      .m_valid(m_valid0), .m_ready(l_m_ready), .busy(busy0));

   alu_op_sequencer #(.ALU_LAT(4)) u_lat4 (
      .clk(clk), .rst(rst), .s_data(l_s_data), .s_valid(l_s_valid), .s_ready(s_ready4),
      .A(a4), .B(b4), .sel(sel4), .C(l_C), .Z(l_Z), .m_data(m_data4), .m_zero(m_zero4),
      .m_valid(m_valid4), .m_ready(l_m_ready), .busy(busy4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      s_data  = b;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1; C = 8'sd0; Z = 1'b0;
      l_s_valid = 1'b0; l_s_data = 8'h00; l_C = 8'sd2; l_Z = 1'b0; l_m_ready = 1'b1;
      tick(); tick();
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if ({A, B, sel} !== 19'd0) begin bad++; $display("FAIL rst_regs got=%h/%h/%h want=0", A, B, sel); end
      total++; if ({m_data, m_zero, m_valid} !== 10'd0) begin bad++; $display("FAIL rst_m got=%h/%b/%b want=0", m_data, m_zero, m_valid); end
      rst = 1'b0;
      #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready got=%b want=1", s_ready); end
   endtask

   // 5 + (-3), ALU result driven as 2; first byte on the first edge after reset
   task automatic test_add();
      m_ready = 1'b1; C = 8'sd2; Z = 1'b0;
      send_byte(8'd5); send_byte(8'hFD); send_byte(8'h00);
      total++; if (A !== 8'sd5) begin bad++; $display("FAIL add_A got=%h want=05", A); end
      total++; if (B !== 8'hFD) begin bad++; $display("FAIL add_B got=%h want=fd", B); end
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL add_sel got=%h want=0", sel); end
      total++; if ({busy, s_ready, m_valid} !== 3'b100) begin bad++; $display("FAIL add_wait got=%b want=100", {busy, s_ready, m_valid}); end
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_early got=%b want=0", m_valid); end
      tick();
      total++; if ({m_valid, m_data, m_zero} !== {1'b1, 8'h02, 1'b0}) begin bad++; $display("FAIL add_res got=%b/%h/%b want=1/02/0", m_valid, m_data, m_zero); end
      total++; if ({busy, s_ready} !== 2'b01) begin bad++; $display("FAIL add_idle got=%b want=01", {busy, s_ready}); end
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", m_valid); end
   endtask

   task automatic test_sel_mask();
      C = 8'sd0; Z = 1'b1;
      send_byte(8'd7); send_byte(8'd7); send_byte(8'h0B);
      total++; if (sel !== 3'd3) begin bad++; $display("FAIL mask_sel got=%h want=3", sel); end
      tick(); tick();
      total++; if ({m_valid, m_data, m_zero} !== {1'b1, 8'h00, 1'b1}) begin bad++; $display("FAIL mask_res got=%b/%h/%b want=1/00/1", m_valid, m_data, m_zero); end
      tick();
   endtask

   task automatic test_back_to_back_stall();
      m_ready = 1'b0; C = 8'sd30; Z = 1'b0;
      send_byte(8'd10); send_byte(8'd20); send_byte(8'd1);
      tick(); tick();
      total++; if ({m_valid, m_data} !== {1'b1, 8'h1E}) begin bad++; $display("FAIL stall_first got=%b/%h want=1/1e", m_valid, m_data); end
      C = 8'hFB;  // -5
      send_byte(8'd3); send_byte(8'd4); send_byte(8'd2);
      tick(); tick();
      s_data = 8'h55; s_valid = 1'b1;
      repeat (3) tick();
      total++; if ({s_ready, busy} !== 2'b01) begin bad++; $display("FAIL stall_ctl got=%b want=01", {s_ready, busy}); end
      total++; if ({A, B, sel} !== {8'h03, 8'h04, 3'd2}) begin bad++; $display("FAIL stall_regs got=%h/%h/%h want=03/04/2", A, B, sel); end
      total++; if ({m_valid, m_data} !== {1'b1, 8'h1E}) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/1e", m_valid, m_data); end
      s_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      total++; if ({m_valid, m_data, busy} !== {1'b1, 8'hFB, 1'b0}) begin bad++; $display("FAIL stall_swap got=%b/%h/%b want=1/fb/0", m_valid, m_data, busy); end
      tick();
      total++; if ({m_valid, m_data} !== {1'b1, 8'hFB}) begin bad++; $display("FAIL stall_keep got=%b/%h want=1/fb", m_valid, m_data); end
      m_ready = 1'b1;
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", m_valid); end
   endtask

   // 100, -100, 1 with one idle cycle before every byte; result left pending
   task automatic test_gaps();
      m_ready = 1'b0; C = 8'sd0; Z = 1'b1;
      s_data = 8'd100; s_valid = 1'b0; tick();
      total++; if (A !== 8'sd3) begin bad++; $display("FAIL gap_A_hold got=%h want=03", A); end
      s_valid = 1'b1; tick();
      s_data = 8'h9C; s_valid = 1'b0; tick();
      total++; if ({A, B} !== {8'h64, 8'h04}) begin bad++; $display("FAIL gap_B_hold got=%h/%h want=64/04", A, B); end
      s_valid = 1'b1; tick();
      s_data = 8'd1; s_valid = 1'b0; tick();
      total++; if ({sel, busy} !== {3'd2, 1'b1}) begin bad++; $display("FAIL gap_sel_hold got=%h/%b want=2/1", sel, busy); end
      s_valid = 1'b1; tick();
      s_valid = 1'b0;
      total++; if ({A, B, sel} !== {8'h64, 8'h9C, 3'd1}) begin bad++; $display("FAIL gap_regs got=%h/%h/%h want=64/9c/1", A, B, sel); end
      tick();
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL gap_early got=%b want=0", m_valid); end
      tick();
      total++; if ({m_valid, m_data, m_zero} !== {1'b1, 8'h00, 1'b1}) begin bad++; $display("FAIL gap_res got=%b/%h/%b want=1/00/1", m_valid, m_data, m_zero); end
   endtask

   task automatic test_reset_mid();
      send_byte(8'd9); send_byte(8'd4);
      total++; if ({A, B, busy, m_valid} !== {8'h09, 8'h04, 1'b1, 1'b1}) begin bad++; $display("FAIL mid_pre got=%h/%h/%b/%b want=09/04/1/1", A, B, busy, m_valid); end
      rst = 1'b1;
      #2;
      total++; if ({A, B, sel} !== 19'd0) begin bad++; $display("FAIL mid_regs got=%h/%h/%h want=0", A, B, sel); end
      total++; if ({m_data, m_zero, m_valid, busy, s_ready} !== 12'd0) begin bad++; $display("FAIL mid_out got=%h/%b/%b/%b/%b want=0", m_data, m_zero, m_valid, busy, s_ready); end
      tick();
      rst = 1'b0; m_ready = 1'b1; C = 8'sd1; Z = 1'b0;
      send_byte(8'hFE); send_byte(8'd3); send_byte(8'd2);
      total++; if ({A, B, sel} !== {8'hFE, 8'h03, 3'd2}) begin bad++; $display("FAIL mid_next got=%h/%h/%h want=fe/03/2", A, B, sel); end
      tick(); tick();
      total++; if ({m_valid, m_data} !== {1'b1, 8'h01}) begin bad++; $display("FAIL mid_res got=%b/%h want=1/01", m_valid, m_data); end
   endtask

   task automatic test_latency();
      int seen0, seen4;
      seen0 = 0; seen4 = 0;
      l_s_data = 8'd1; l_s_valid = 1'b1; tick();
      l_s_data = 8'd1; tick();
      l_s_data = 8'd0; tick();
      l_s_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (m_valid0 && seen0 == 0) seen0 = k;
         if (m_valid4 && seen4 == 0) seen4 = k;
      end
      total++; if (seen0 !== 1) begin bad++; $display("FAIL lat0_edges got=%0d want=1", seen0); end
      total++; if (seen4 !== 5) begin bad++; $display("FAIL lat4_edges got=%0d want=5", seen4); end
      total++; if ({m_data0, m_data4} !== {8'h02, 8'h02}) begin bad++; $display("FAIL lat_data got=%h/%h want=02/02", m_data0, m_data4); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sel_mask();
      test_back_to_back_stall();
      test_gaps();
      test_reset_mid();
      test_latency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
